// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds mul/div latency default, field widths and FSM state encoding.
package pipeline_hazard_ctrl_pkg;

    localparam int MD_LATENCY_DEF = 4;
    localparam int REG_W          = 5;
    localparam int PERF_W         = 16;
    localparam int MD_CNT_W       = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX decode inputs, stall/flush outputs.
// slave = controller side, master = pipeline/testbench side.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_W-1:0]  ID_Rs;
    logic [REG_W-1:0]  ID_Rt;
    logic              ID_uses_Rt;
    logic              ID_md_start;
    logic              ID_md_read;
    logic              ID_EX_MemRead;
    logic [REG_W-1:0]  ID_EX_WriteReg;
    logic              EX_redirect;
    logic              PC_en;
    logic              IF_ID_en;
    logic              IF_ID_flush;
    logic              ID_EX_flush;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_events;

    modport slave (
        input  ID_Rs, ID_Rt, ID_uses_Rt, ID_md_start, ID_md_read,
        input  ID_EX_MemRead, ID_EX_WriteReg, EX_redirect,
        output PC_en, IF_ID_en, IF_ID_flush, ID_EX_flush, md_busy,
        output stall_cycles, flush_events
    );

    modport master (
        output ID_Rs, ID_Rt, ID_uses_Rt, ID_md_start, ID_md_read,
        output ID_EX_MemRead, ID_EX_WriteReg, EX_redirect,
        input  PC_en, IF_ID_en, IF_ID_flush, ID_EX_flush, md_busy,
        input  stall_cycles, flush_events
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// Mul/div occupancy timer: start loads MD_LATENCY, busy until count ends.
// Ports: clk, rst_n, start (issue accepted this cycle), busy (registered).
module md_busy_timer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    md_state_e           state;
    logic [MD_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (start) begin
                        state <= MD_WAIT;
                        cnt   <= MD_CNT_W'(MD_LATENCY);
                        busy  <= 1'b1;
                    end
                end
                MD_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == MD_CNT_W'(1)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler: load-use, mul/div busy and EX redirect handling.
// Ports: clk, rst_n, hz (slave bundle). Perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    logic load_use;
    logic md_hazard;
    logic stall;
    logic md_issue;
    logic md_busy_q;

    assign load_use = hz.ID_EX_MemRead
                   && (hz.ID_EX_WriteReg != '0)
                   && ((hz.ID_EX_WriteReg == hz.ID_Rs)
                    || (hz.ID_uses_Rt && (hz.ID_EX_WriteReg == hz.ID_Rt)));

    assign md_hazard = md_busy_q && (hz.ID_md_start || hz.ID_md_read);
    assign stall     = load_use || md_hazard;

    // A squashed or held mul/div must not occupy the unit.
    assign md_issue = hz.ID_md_start && !stall && !hz.EX_redirect;

    md_busy_timer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_issue),
        .busy  (md_busy_q)
    );

    assign hz.md_busy = md_busy_q;

    always_comb begin
        hz.PC_en       = 1'b1;
        hz.IF_ID_en    = 1'b1;
        hz.IF_ID_flush = 1'b0;
        hz.ID_EX_flush = 1'b0;
        if (!rst_n) begin
            hz.PC_en       = 1'b0;
            hz.IF_ID_en    = 1'b0;
            hz.IF_ID_flush = 1'b1;
            hz.ID_EX_flush = 1'b1;
        end else if (hz.EX_redirect) begin
            hz.IF_ID_flush = 1'b1;
            hz.ID_EX_flush = 1'b1;
        end else if (stall) begin
            hz.PC_en       = 1'b0;
            hz.IF_ID_en    = 1'b0;
            hz.ID_EX_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !hz.EX_redirect && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (hz.EX_redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_events = flush_cnt;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_events = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage MIPS pipeline. It sits beside the forwarding unit and decides, every cycle, whether the PC and IF/ID register advance, whether a bubble goes into ID/EX, and whether younger instructions are squashed. It covers three cases:
- load-use hazards, which forwarding cannot cover;
- the multi-cycle multiply/divide unit;
- taken branches and jumps resolved in EX.

## Interface
- MD_LATENCY, 4, cycles the mul/div unit occupies after issue; legal range 2..15
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_uses_Rt  in  1  instruction in ID reads rt as a source
- ID_md_start  in  1  instruction in ID is mult/multu/div/divu
- ID_md_read  in  1  instruction in ID is mfhi/mflo
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_WriteReg  in  5  destination of instruction in EX
- EX_redirect  in  1  taken branch or jump resolved in EX this cycle
- PC_en  out  1  PC register load enable
- IF_ID_en  out  1  IF/ID register load enable
- IF_ID_flush  out  1  clear IF/ID to nop on next edge
- ID_EX_flush  out  1  load nop (bubble) into ID/EX on next edge
- md_busy  out  1  mul/div unit occupied
- stall_cycles  out  16  perf counter, see Configuration
- flush_events  out  16  perf counter, see Configuration

## Operation
**Reset.** While rst_n is low:
- PC_en=0, IF_ID_en=0, IF_ID_flush=1, ID_EX_flush=1, md_busy=0.
- State is RUN, md counter is 0, both perf counters are 0.

**load_use.** ID_EX_MemRead & ID_EX_WriteReg!=0 & (ID_EX_WriteReg==ID_Rs | (ID_uses_Rt & ID_EX_WriteReg==ID_Rt)).

**md_hazard.** md_busy & (ID_md_start | ID_md_read).

**FSM, 2 states.**
- RUN: md_busy=0. Goes to MD_WAIT on ID_md_start & ~stall & ~EX_redirect; md counter loads MD_LATENCY.
- MD_WAIT: md_busy=1. Counter decrements each cycle. Goes back to RUN when the counter reaches 1 and decrements to 0.

**Output priority** (all outputs combinational from inputs and state):
1. EX_redirect: PC_en=1, IF_ID_en=1, IF_ID_flush=1, ID_EX_flush=1. The redirect overrides any stall.
2. md_hazard or load_use (stall=1): PC_en=0, IF_ID_en=0, IF_ID_flush=0, ID_EX_flush=1.
3. Otherwise: PC_en=1, IF_ID_en=1, both flushes 0.

**Boundary cases.**
- A mul/div op squashed by EX_redirect, or held by a stall, does not start the counter.
- EX_redirect does not cancel an mul/div op already in MD_WAIT; the counter keeps running.
- An instruction that is both load_use and md_hazard causes one stall cycle per cycle the condition holds, not two.
- rst_n asserted mid-MD_WAIT returns the FSM to RUN immediately (asynchronously).
- Register 0 never causes a load_use stall.

## Timing
- Zero-latency decision: outputs for cycle N depend on cycle-N inputs and the state registered at the edge ending cycle N-1.
- mul/div issue accepted in cycle T: md_busy is high in cycles T+1 .. T+MD_LATENCY and low in T+MD_LATENCY+1.
- A dependent mfhi/mflo is held in ID through T+MD_LATENCY and advances in T+MD_LATENCY+1.
- Load-use stall lasts exactly one cycle: the bubble moves the load to MEM, and forwarding from MEM/WB resolves the dependency.
- Flush takes effect at the edge ending the cycle in which EX_redirect is high; the instruction in EX (the branch) is unaffected.

## Configuration
- HAZARD_PERF_CNT_EN defined: registered counters.
  - stall_cycles increments on every cycle with stall=1 & ~EX_redirect.
  - flush_events increments on every cycle with EX_redirect=1.
  - Both saturate at 16'hFFFF and are cleared by rst_n.
- Not defined: no counter registers; stall_cycles and flush_events are tied to 16'h0. The ports remain present.

## Structure
- Shared package:
  - MD_LATENCY default
  - REG_W=5
  - FSM state encoding RUN=1'b0, MD_WAIT=1'b1
  - perf counter width 16
- One sub-module, md_busy_timer: counter, load, decrement and busy flag. The top level keeps the hazard decode, the priority mux and the perf counters.

## Test plan
- Load-use on rs: lw $8 in EX (ID_EX_MemRead=1, ID_EX_WriteReg=8), ID_Rs=8 -> one cycle with PC_en=0, IF_ID_en=0, ID_EX_flush=1, then normal flow.
- No false stalls:
  - ID_EX_WriteReg=0 with ID_Rs=0 -> no stall.
  - ID_Rt matches but ID_uses_Rt=0 -> no stall.
- MD_LATENCY=4: mult issues at T, mflo reaches ID at T+1 -> md_busy high T+1..T+4, stall T+1..T+4, mflo advances at T+5.
- EX_redirect while load_use is also true -> IF_ID_flush=1, ID_EX_flush=1, PC_en=1; with HAZARD_PERF_CNT_EN, flush_events +1 and stall_cycles unchanged.
- rst_n low at T+2 of a mul/div wait -> md_busy=0 immediately; after release, an mfhi in ID advances with no stall.
- HAZARD_PERF_CNT_EN saturation: preload by forcing 16'hFFFE, then 3 stall cycles -> stall_cycles holds 16'hFFFF.
